// File: rtl/imem_loader.sv
// Instruction memory loader: takes a length-prefixed, checksummed byte stream,
// assembles big-endian 16-bit words and writes them through the instruction
// memory word port. The CPU is held until a verified image is in place.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  S_LEN_HI  | waiting for high byte of word count
//  S_LEN_LO  | waiting for low byte of word count; range check on accept
//  S_DAT_HI  | waiting for high byte of next instruction word
//  S_DAT_LO  | waiting for low byte; accept triggers the memory write
//  S_CHK_HI  | waiting for high byte of checksum
//  S_CHK_LO  | waiting for low byte; compare against running sum
//  S_DONE    | image verified, CPU released, stream closed
//  S_ERR     | bad length or checksum, CPU held, stream closed
module imem_loader #(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 10
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   input  logic              restart,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [15:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [15:0]       words_loaded
);

   typedef enum logic [2:0] {
      S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO,
      S_CHK_HI, S_CHK_LO, S_DONE,   S_ERR
   } state_t;

   state_t            state_q, state_d;
   logic [7:0]        hi_q, hi_d;
   logic [15:0]       len_q, len_d;
   logic [15:0]       sum_q, sum_d;
   logic [15:0]       wl_q, wl_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       wdata_q, wdata_d;
   logic              hs;
   logic [15:0]       rx_word;

   // Stream is open in every loading state; closed once a verdict is reached.
   assign byte_ready   = (state_q != S_DONE) && (state_q != S_ERR);
   assign hs           = byte_valid & byte_ready;
   assign rx_word      = {hi_q, byte_in};
   assign cpu_hold     = (state_q != S_DONE);
   assign done         = (state_q == S_DONE);
   assign error        = (state_q == S_ERR);
   assign imem_we      = we_q;
   assign imem_addr    = addr_q;
   assign imem_wdata   = wdata_q;
   assign words_loaded = wl_q;

   // Register stage for the FSM and its datapath.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_LEN_HI;
         hi_q    <= '0;
         len_q   <= '0;
         sum_q   <= '0;
         wl_q    <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         len_q   <= len_d;
         sum_q   <= sum_d;
         wl_q    <= wl_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Next-state and datapath updates; restart wins over a same-cycle byte.
   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      len_d   = len_q;
      sum_d   = sum_q;
      wl_d    = wl_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (restart) begin
         state_d = S_LEN_HI;
         sum_d   = '0;
         wl_d    = '0;
      end else if (hs) begin
         case (state_q)
            S_LEN_HI: begin
               hi_d    = byte_in;
               state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
               len_d = rx_word;
               // 17-bit compare so a DEPTH of 65536 still works.
               if ({1'b0, rx_word} > 17'(DEPTH))
                  state_d = S_ERR;
               else if (rx_word == 16'd0)
                  state_d = S_CHK_HI;
               else
                  state_d = S_DAT_HI;
            end
            S_DAT_HI: begin
               hi_d    = byte_in;
               state_d = S_DAT_LO;
            end
            S_DAT_LO: begin
               // words_loaded doubles as the write index; LEN <= DEPTH keeps it in range.
               we_d    = 1'b1;
               wdata_d = rx_word;
               addr_d  = wl_q[ADDR_W-1:0];
               sum_d   = sum_q + rx_word;
               wl_d    = wl_q + 16'd1;
               state_d = ((wl_q + 16'd1) == len_q) ? S_CHK_HI : S_DAT_HI;
            end
            S_CHK_HI: begin
               hi_d    = byte_in;
               state_d = S_CHK_LO;
            end
            S_CHK_LO: begin
               state_d = (rx_word == sum_q) ? S_DONE : S_ERR;
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and random streams, reference results
// computed from the stream format (word list, modular sum, length bound).
module tb_imem_loader;

   localparam int DEPTH  = 1024;
   localparam int ADDR_W = 10;

   logic              clock = 1'b0;
   logic              reset;
   logic [7:0]        byte_in;
   logic              byte_valid;
   logic              byte_ready;
   logic              restart;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [15:0]       imem_wdata;
   logic              cpu_hold;
   logic              done;
   logic              error;
   logic [15:0]       words_loaded;

   imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clock        (clock),
      .reset        (reset),
      .byte_in      (byte_in),
      .byte_valid   (byte_valid),
      .byte_ready   (byte_ready),
      .restart      (restart),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .cpu_hold     (cpu_hold),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clock = ~clock;

   int n_assert = 0;
   int n_fail   = 0;

   logic [15:0]       words[$];
   logic [7:0]        stream[$];
   logic [ADDR_W-1:0] wq_addr[$];
   logic [15:0]       wq_data[$];
   logic [15:0]       wq_wl[$];

   // Record every write strobe seen, with the count visible alongside it.
   always @(negedge clock) begin
      if (!reset && imem_we) begin
         wq_addr.push_back(imem_addr);
         wq_data.push_back(imem_wdata);
         wq_wl.push_back(words_loaded);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_writes();
      wq_addr.delete();
      wq_data.delete();
      wq_wl.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int   cyc;
      logic rdy;
      for (int g = 0; g < gap; g++) begin
         byte_valid = 1'b0;
         byte_in    = 8'($urandom);
         @(posedge clock); #1;
      end
      byte_valid = 1'b1;
      byte_in    = b;
      cyc = 0;
      do begin
         @(negedge clock);
         rdy = byte_ready;
         @(posedge clock); #1;
         cyc++;
      end while (!rdy && cyc < 50);
      chk("handshake", 32'(rdy), 32'd1);
      byte_valid = 1'b0;
      byte_in    = 8'($urandom);
   endtask

   task automatic do_restart();
      restart = 1'b1;
      @(posedge clock); #1;
      restart = 1'b0;
      chk("rst_ready", 32'(byte_ready), 32'd1);
      chk("rst_done",  32'(done),       32'd0);
      chk("rst_error", 32'(error),      32'd0);
      chk("rst_hold",  32'(cpu_hold),   32'd1);
      chk("rst_wl",    32'(words_loaded), 32'd0);
      clear_writes();
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, " ready"}, 32'(byte_ready),   32'd1);
      chk({tag, " we"},    32'(imem_we),      32'd0);
      chk({tag, " addr"},  32'(imem_addr),    32'd0);
      chk({tag, " wdata"}, 32'(imem_wdata),   32'd0);
      chk({tag, " hold"},  32'(cpu_hold),     32'd1);
      chk({tag, " done"},  32'(done),         32'd0);
      chk({tag, " error"}, 32'(error),        32'd0);
      chk({tag, " wl"},    32'(words_loaded), 32'd0);
   endtask

   // Build a stream from `words`, send it, and compare against the format rules.
   // gap_mode: 0 back-to-back, 1 one idle cycle before each byte, 2 random idle.
   task automatic run_case(input string name, input logic [15:0] len,
                           input logic corrupt, input int gap_mode);
      logic [15:0] sum;
      logic [15:0] chkv;
      logic        len_ok;
      logic        exp_done;
      int          exp_n;
      int          n;
      int          gap;
      sum = 16'd0;
      foreach (words[i]) sum = sum + words[i];
      chkv     = corrupt ? sum + 16'd1 : sum;
      len_ok   = (int'(len) <= DEPTH);
      exp_done = len_ok && !corrupt;
      exp_n    = len_ok ? int'(len) : 0;
      stream.delete();
      stream.push_back(len[15:8]);
      stream.push_back(len[7:0]);
      if (len_ok) begin
         foreach (words[i]) begin
            stream.push_back(words[i][15:8]);
            stream.push_back(words[i][7:0]);
         end
         stream.push_back(chkv[15:8]);
         stream.push_back(chkv[7:0]);
      end
      clear_writes();
      foreach (stream[i]) begin
         gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 3));
         send_byte(stream[i], gap);
      end
      repeat (3) @(posedge clock);
      #1;
      chk({name, " done"},   32'(done),         32'(exp_done));
      chk({name, " error"},  32'(error),        32'(!exp_done));
      chk({name, " hold"},   32'(cpu_hold),     32'(!exp_done));
      chk({name, " ready"},  32'(byte_ready),   32'd0);
      chk({name, " wl"},     32'(words_loaded), 32'(exp_n));
      chk({name, " nwr"},    32'(wq_addr.size()), 32'(exp_n));
      n = (wq_addr.size() < exp_n) ? wq_addr.size() : exp_n;
      for (int i = 0; i < n; i++) begin
         chk({name, " waddr"}, 32'(wq_addr[i]), 32'(i));
         chk({name, " wdata"}, 32'(wq_data[i]), 32'(words[i]));
         chk({name, " wwl"},   32'(wq_wl[i]),   32'(i + 1));
      end
   endtask

   task automatic set_test1_words();
      words.delete();
      words.push_back(16'h410F);
      words.push_back(16'h4207);
   endtask

   initial begin
      int len;
      reset      = 1'b1;
      restart    = 1'b0;
      byte_valid = 1'b0;
      byte_in    = 8'h00;
      #12;
      check_reset_values("por");
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;

      // 1) basic two-word image
      set_test1_words();
      run_case("t1", 16'd2, 1'b0, 0);

      // 2) bad checksum 8317
      do_restart();
      set_test1_words();
      run_case("t2", 16'd2, 1'b1, 0);

      // 3) LEN = DEPTH+1 and LEN = FFFF rejected with no writes
      do_restart();
      words.delete();
      run_case("t3", 16'(DEPTH + 1), 1'b0, 0);
      do_restart();
      words.delete();
      run_case("t3max", 16'hFFFF, 1'b0, 0);

      // 4) empty image
      do_restart();
      words.delete();
      run_case("t4", 16'd0, 1'b0, 0);

      // 5) byte_valid toggling
      do_restart();
      set_test1_words();
      run_case("t5", 16'd2, 1'b0, 1);

      // LEN = DEPTH fills the memory to the last address
      do_restart();
      words.delete();
      for (int i = 0; i < DEPTH; i++) words.push_back(16'($urandom));
      run_case("full", 16'(DEPTH), 1'b0, 0);

      // random images with random gaps and occasional bad checksums
      for (int r = 0; r < 10; r++) begin
         do_restart();
         words.delete();
         len = int'($urandom_range(0, 12));
         for (int i = 0; i < len; i++) words.push_back(16'($urandom));
         run_case("rand", 16'(len), ($urandom_range(0, 3) == 0), 2);
      end

      // 6a) restart collides with a data hi-byte handshake
      do_restart();
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      send_byte(8'h41, 0);
      send_byte(8'h0F, 0);
      byte_valid = 1'b1;
      byte_in    = 8'h42;
      restart    = 1'b1;
      @(posedge clock); #1;
      restart    = 1'b0;
      byte_valid = 1'b0;
      chk("t6 wl_cleared",   32'(words_loaded), 32'd0);
      chk("t6 hold",         32'(cpu_hold),     32'd1);
      chk("t6 ready",        32'(byte_ready),   32'd1);
      set_test1_words();
      run_case("t6", 16'd2, 1'b0, 0);

      // 6b) async reset in the middle of a word
      do_restart();
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      send_byte(8'h41, 0);
      send_byte(8'h0F, 0);
      send_byte(8'h42, 0);
      chk("t6r pre_wl", 32'(words_loaded), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check_reset_values("t6r");
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;
      set_test1_words();
      run_case("t6r", 16'd2, 1'b0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
